// File: rtl/wb_sram_bank_ctrl.sv
// wb_sram_bank_ctrl: Wishbone classic slave in front of NUM_BANKS single-port
// SRAM macros with active-low CSB/WEB and a byte write mask. One access is in
// flight at a time. Each access produces a one-cycle macro strobe and then a
// one-cycle ack.
//
// Optional feature macro: SRAM_ERR_EN. When it is defined, an address outside
// the window returns a one-cycle wbs_err_o instead of an ack.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs_*_i / wbs_*_o    Wishbone classic slave (byte address, 32-bit data)
//   sram_csb_o           per-bank chip select, active-low
//   sram_web_o           shared write enable, active-low
//   sram_wmask_o         shared byte write mask
//   sram_addr_o          shared word address within the bank
//   sram_din_o           shared write data
//   sram_dout_i          read data; bank b is at [32b+31:32b]
module wb_sram_bank_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_WORDS = 1024,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic [31:0]                     wbs_dat_o,
  output logic                            wbs_ack_o,
  output logic                            wbs_err_o,
  output logic [NUM_BANKS-1:0]            sram_csb_o,
  output logic                            sram_web_o,
  output logic [3:0]                      sram_wmask_o,
  output logic [$clog2(BANK_WORDS)-1:0]   sram_addr_o,
  output logic [31:0]                     sram_din_o,
  input  logic [32*NUM_BANKS-1:0]         sram_dout_i
);

  localparam int unsigned AW     = $clog2(BANK_WORDS);
  localparam int unsigned BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned WIN_AW = $clog2(NUM_BANKS * BANK_WORDS * 4);
  localparam int unsigned WW     = WIN_AW - 2;
  localparam int unsigned CW     = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        bank_q, bank_d;
  logic                 we_q, we_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          dat_q, dat_d;
  logic                 ack_q, ack_d;
  logic [NUM_BANKS-1:0] csb_q, csb_d;
  logic                 web_q, web_d;
  logic [3:0]           wmask_q, wmask_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [31:0]          din_q, din_d;
`ifdef SRAM_ERR_EN
  logic                 err_q, err_d;
`endif

  // Address decode: the window is aligned, so a hit is a compare of the upper bits.
  logic [WW-1:0] req_word;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_bank;
  logic          req_hit;
  logic          unused_adr;

  assign req_word   = wbs_adr_i[WIN_AW-1:2];
  assign req_addr   = req_word[AW-1:0];
  assign req_bank   = BW'(req_word >> AW);
  assign req_hit    = (wbs_adr_i >> WIN_AW) == (BASE_ADDR >> WIN_AW);
  assign unused_adr = ^wbs_adr_i[1:0];

  // Select the read data of the bank that was strobed.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_q == BW'(b)) rd_word = sram_dout_i[32*b +: 32];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    ack_d   = 1'b0;
    csb_d   = '1;
    web_d   = 1'b1;
    wmask_d = 4'h0;
    addr_d  = addr_q;
    din_d   = din_q;
`ifdef SRAM_ERR_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (req_hit) begin
            bank_d  = req_bank;
            we_d    = wbs_we_i;
            addr_d  = req_addr;
            din_d   = wbs_dat_i;
            web_d   = ~wbs_we_i;
            wmask_d = wbs_we_i ? wbs_sel_i : 4'h0;
            // A write with no byte selected has nothing to store, so the macro is not strobed.
            if (!(wbs_we_i && (wbs_sel_i == 4'h0))) begin
              csb_d = ~(NUM_BANKS'(1) << req_bank);
            end
            state_d = S_ISSUE;
          end else begin
`ifdef SRAM_ERR_EN
            err_d   = 1'b1;
`else
            ack_d   = 1'b1;
`endif
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        // Dropping cyc here abandons the response, but the macro has already seen the strobe.
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (we_q) begin
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = CW'(READ_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          dat_d   = rd_word;
          ack_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        // The response is presented in this cycle; stb is not sampled.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      csb_q   <= '1;
      web_q   <= 1'b1;
      wmask_q <= 4'h0;
      addr_q  <= '0;
      din_q   <= '0;
`ifdef SRAM_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
`ifdef SRAM_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign wbs_dat_o    = dat_q;
  assign wbs_ack_o    = ack_q;
`ifdef SRAM_ERR_EN
  assign wbs_err_o    = err_q;
`else
  assign wbs_err_o    = 1'b0;
`endif
  assign sram_csb_o   = csb_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;

endmodule
